// File: rtl/issue_scoreboard.sv
// issue_scoreboard: dispatches one decoded instruction per cycle to ALU/LD/MUL/DIV,
// times each unit's latency with a countdown counter, raises per-unit completion
// strobes, and tracks outstanding destination registers in a 16-bit scoreboard.
// Optional build macro SB_WB_BYPASS_EN: when defined, a register being written back
// this cycle is not treated as a data hazard, so a waiting consumer issues in the
// same cycle as the writeback instead of one cycle later.
module issue_scoreboard #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned LD_LAT  = 2,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  in_unit,
  input  logic [3:0]  in_Rd,
  input  logic [3:0]  in_Rn,
  input  logic [3:0]  in_Rm,
  input  logic        in_use_rn,
  input  logic        in_use_rm,
  input  logic        wb_valid,
  input  logic [3:0]  wb_Rd,
  output logic        stall,
  output logic [3:0]  issue_en,
  output logic [3:0]  exe_done,
  output logic [3:0]  unit_busy,
  output logic [15:0] pending
);

  localparam int unsigned N_UNITS = 4;
  localparam int unsigned N_REGS  = 16;

  // Latencies packed by strobe bit position: [3]=ALU, [2]=LD, [1]=MUL, [0]=DIV.
  localparam logic [N_UNITS*CNT_W-1:0] LAT_PACK = {
    CNT_W'(ALU_LAT), CNT_W'(LD_LAT), CNT_W'(MUL_LAT), CNT_W'(DIV_LAT)
  };

  logic [CNT_W-1:0]  r_cnt [N_UNITS];
  logic [N_REGS-1:0] r_pending;

  logic [N_UNITS-1:0] w_sel_oh;
  logic [N_UNITS-1:0] w_free;
  logic [N_REGS-1:0]  w_pend_eff;
  logic               w_struct;
  logic               w_raw;

  // Per-unit status derived directly from the countdown counters.
  always_comb begin
    w_free    = '0;
    exe_done  = '0;
    unit_busy = '0;
    for (int b = 0; b < int'(N_UNITS); b++) begin
      w_free[b]    = (r_cnt[b] <= CNT_W'(1));
      exe_done[b]  = (r_cnt[b] == CNT_W'(1));
      unit_busy[b] = (r_cnt[b] != '0);
    end
  end

  // Hazard detection and issue decision; a unit may accept a new op in its done cycle.
  always_comb begin
    w_sel_oh   = 4'(4'b1000 >> in_unit);
    w_pend_eff = r_pending;
`ifdef SB_WB_BYPASS_EN
    if (wb_valid) begin
      w_pend_eff = r_pending & ~(16'b1 << wb_Rd);
    end
`endif
    w_struct = |(w_sel_oh & ~w_free);
    w_raw    = w_pend_eff[in_Rd]
             | (in_use_rn & w_pend_eff[in_Rn])
             | (in_use_rm & w_pend_eff[in_Rm]);
    stall    = in_valid & (~rst_n | w_struct | w_raw);
    issue_en = (in_valid & ~stall) ? w_sel_oh : '0;
  end

  // Countdown per unit: reload on issue, otherwise decrement and saturate at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < int'(N_UNITS); b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < int'(N_UNITS); b++) begin
        if (issue_en[b]) begin
          r_cnt[b] <= LAT_PACK[b*CNT_W +: CNT_W];
        end else if (r_cnt[b] != '0) begin
          r_cnt[b] <= r_cnt[b] - CNT_W'(1);
        end
      end
    end
  end

  // Scoreboard: writeback clears, issue sets; set wins when both hit the same register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~((wb_valid ? 16'b1 : 16'b0) << wb_Rd))
                 | ((|issue_en) ? (16'b1 << in_Rd) : 16'b0);
    end
  end

  assign pending = r_pending;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized self-checking bench for issue_scoreboard. The reference model keeps,
// per unit, the absolute cycle in which its op completes, and a plain bit array of
// outstanding destination registers.
module tb_issue_scoreboard;

  localparam int N_CYC = 4000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_unit;
  logic [3:0]  in_Rd;
  logic [3:0]  in_Rn;
  logic [3:0]  in_Rm;
  logic        in_use_rn;
  logic        in_use_rm;
  logic        wb_valid;
  logic [3:0]  wb_Rd;
  logic        stall;
  logic [3:0]  issue_en;
  logic [3:0]  exe_done;
  logic [3:0]  unit_busy;
  logic [15:0] pending;

  issue_scoreboard dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_unit   (in_unit),
    .in_Rd     (in_Rd),
    .in_Rn     (in_Rn),
    .in_Rm     (in_Rm),
    .in_use_rn (in_use_rn),
    .in_use_rm (in_use_rm),
    .wb_valid  (wb_valid),
    .wb_Rd     (wb_Rd),
    .stall     (stall),
    .issue_en  (issue_en),
    .exe_done  (exe_done),
    .unit_busy (unit_busy),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int cyc;

  // Latency by strobe bit: [3]=ALU, [2]=LD, [1]=MUL, [0]=DIV.
  int lat_of [4];
  // Cycle (interval after a posedge, counted from 0) in which each unit's op completes.
  int done_at [4];
  bit m_pend [16];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    bit          held;
    int          sel;
    bit          free;
    bit          raw;
    bit          pend_eff [16];
    logic        e_stall;
    logic [3:0]  e_issue;
    logic [3:0]  e_done;
    logic [3:0]  e_busy;
    logic [15:0] e_pend;
    int          pick;

    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    held  = 1'b0;
    lat_of[3] = 1;
    lat_of[2] = 2;
    lat_of[1] = 3;
    lat_of[0] = 16;
    for (int b = 0; b < 4; b++) done_at[b] = -1;
    for (int r = 0; r < 16; r++) m_pend[r] = 1'b0;

    rst_n = 1'b0; in_valid = 1'b1; in_unit = '0; in_Rd = '0; in_Rn = '0; in_Rm = '0;
    in_use_rn = 1'b0; in_use_rm = 1'b0; wb_valid = 1'b0; wb_Rd = '0;

    for (int k = 0; k < N_CYC; k++) begin
      @(negedge clk);
      // Drive stimulus; a stalled instruction is kept stable as decode must.
      rst_n = (cyc < 3 || $urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      if (cyc < 3) begin
        in_valid = 1'b1;
      end else if (!held) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_unit   = 2'($urandom_range(0, 3));
        in_Rd     = 4'($urandom_range(0, 15));
        in_Rn     = 4'($urandom_range(0, 15));
        in_Rm     = 4'($urandom_range(0, 15));
        in_use_rn = 1'($urandom_range(0, 1));
        in_use_rm = 1'($urandom_range(0, 1));
      end
      wb_valid = ($urandom_range(0, 2) == 0);
      pick = $urandom_range(0, 15);
      for (int t = 0; t < 16; t++) begin
        if (!m_pend[pick]) pick = $urandom_range(0, 15);
      end
      wb_Rd = 4'(pick);

      #1;
      // Expected values from the model state for this cycle.
      sel  = 3 - int'(in_unit);
      free = (cyc >= done_at[sel]);
      for (int r = 0; r < 16; r++) pend_eff[r] = m_pend[r];
`ifdef SB_WB_BYPASS_EN
      if (wb_valid) pend_eff[wb_Rd] = 1'b0;
`endif
      raw = pend_eff[in_Rd] || (in_use_rn && pend_eff[in_Rn]) || (in_use_rm && pend_eff[in_Rm]);
      e_stall = in_valid && (!rst_n || !free || raw);
      e_issue = (in_valid && !e_stall) ? 4'(1 << sel) : 4'b0;
      for (int b = 0; b < 4; b++) begin
        e_done[b] = (cyc == done_at[b]);
        e_busy[b] = (cyc <= done_at[b]);
      end
      for (int r = 0; r < 16; r++) e_pend[r] = m_pend[r];

      if (cyc > 0) begin
        chk("stall",     16'(stall),     16'(e_stall));
        chk("issue_en",  16'(issue_en),  16'(e_issue));
        chk("exe_done",  16'(exe_done),  16'(e_done));
        chk("unit_busy", 16'(unit_busy), 16'(e_busy));
        chk("pending",   pending,        e_pend);
      end
      held = e_stall;

      @(posedge clk);
      // Advance the model across this edge.
      if (!rst_n) begin
        for (int b = 0; b < 4; b++) done_at[b] = -1;
        for (int r = 0; r < 16; r++) m_pend[r] = 1'b0;
      end else begin
        if (wb_valid) m_pend[wb_Rd] = 1'b0;
        if (e_issue != 4'b0) begin
          done_at[sel]  = cyc + lat_of[sel];
          m_pend[in_Rd] = 1'b1;
        end
      end
      cyc++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
